// File: rtl/saturn_bus_prog_reader_pkg.sv
// Shared Saturn bus definitions: bus command codes, bus-program entry layout
// and the program reader's FSM encodings.
package saturn_bus_prog_reader_pkg;

   localparam int DEF_ADDR_NIBBLES = 5;
   localparam int DEF_PROG_AW      = 5;
   localparam int ENTRY_CMD_BIT    = 4;

   localparam logic [3:0] BUSCMD_PC_READ     = 4'h0;
   localparam logic [3:0] BUSCMD_DP_READ     = 4'h1;
   localparam logic [3:0] BUSCMD_PC_WRITE    = 4'h2;
   localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h3;
   localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h4;
   localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h5;
   localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h6;
   localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h7;
   localparam logic [3:0] BUSCMD_C_EQ_ID     = 4'h8;
   localparam logic [3:0] BUSCMD_RESET       = 4'h9;

   typedef enum logic [0:0] {
      BUS_ST_IDLE = 1'b0,
      BUS_ST_ADDR = 1'b1
   } bus_state_t;

   // Codes above BUSCMD_RESET are unassigned on this bus.
   function automatic logic buscmd_defined(input logic [3:0] code);
      return (code <= BUSCMD_RESET);
   endfunction

   function automatic logic buscmd_is_addr_load(input logic [3:0] code);
      return (code == BUSCMD_LOAD_PC) || (code == BUSCMD_LOAD_DP);
   endfunction

endpackage

// File: rtl/saturn_bus_prog_reader_if.sv
// Bus-program handshake between the control unit (master) and the program
// reader (slave), plus the Saturn bus replay and status outputs.
interface saturn_bus_prog_reader_if
   import saturn_bus_prog_reader_pkg::*;
#(
   parameter int PROG_AW      = DEF_PROG_AW,
   parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES
);
   logic [PROG_AW-1:0]        wr_address;
   logic [PROG_AW-1:0]        rd_address;
   logic [4:0]                program_data;
   logic                      bus_strobe;
   logic                      bus_cmd;
   logic [3:0]                bus_nibble;
   logic                      bus_busy;
   logic [3:0]                last_cmd;
   logic [4*ADDR_NIBBLES-1:0] addr_value;
   logic                      addr_valid;
   logic                      error;

   modport master (
      output wr_address, program_data,
      input  rd_address, bus_strobe, bus_cmd, bus_nibble, bus_busy,
             last_cmd, addr_value, addr_valid, error
   );

   modport slave (
      input  wr_address, program_data,
      output rd_address, bus_strobe, bus_cmd, bus_nibble, bus_busy,
             last_cmd, addr_value, addr_valid, error
   );
endinterface

// File: rtl/saturn_bus_addr_assembler.sv
// Collects the nibbles following LOAD_PC/LOAD_DP (LSB first) into an address
// and pulses addr_valid when the last one lands.
module saturn_bus_addr_assembler
   import saturn_bus_prog_reader_pkg::*;
#(
   parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES,
   localparam int CNT_W       = $clog2(ADDR_NIBBLES + 1),
   localparam int ADDR_W      = 4 * ADDR_NIBBLES
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              start,
   input  logic              abandon,
   input  logic              nibble_we,
   input  logic [3:0]        nibble,
   output logic              last_nibble,
   output logic [ADDR_W-1:0] addr_value,
   output logic              addr_valid
);
   logic [CNT_W-1:0]  addr_cnt_r;
   logic [CNT_W-1:0]  nib_idx_s;
   logic [ADDR_W-1:0] shadow_r;
   logic [ADDR_W-1:0] shadow_nxt_s;
   logic [ADDR_W-1:0] addr_value_r;
   logic              addr_valid_r;

   assign nib_idx_s   = CNT_W'(ADDR_NIBBLES) - addr_cnt_r;
   assign last_nibble = (addr_cnt_r == CNT_W'(1));

   // Shadow with the incoming nibble merged at its slot.
   always_comb begin
      shadow_nxt_s = shadow_r;
      for (int i = 0; i < ADDR_NIBBLES; i++) begin
         if (nib_idx_s == CNT_W'(i)) begin
            shadow_nxt_s[i*4 +: 4] = nibble;
         end else begin
            shadow_nxt_s[i*4 +: 4] = shadow_r[i*4 +: 4];
         end
      end
   end

   // Counter, shadow and completed-address registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         addr_cnt_r   <= '0;
         shadow_r     <= '0;
         addr_value_r <= '0;
         addr_valid_r <= 1'b0;
      end else begin
         addr_valid_r <= 1'b0;
         if (start) begin
            addr_cnt_r <= CNT_W'(ADDR_NIBBLES);
            shadow_r   <= '0;
         end else if (abandon) begin
            addr_cnt_r <= '0;
         end else if (nibble_we && (addr_cnt_r != '0)) begin
            shadow_r   <= shadow_nxt_s;
            addr_cnt_r <= addr_cnt_r - CNT_W'(1);
            if (last_nibble) begin
               addr_value_r <= shadow_nxt_s;
               addr_valid_r <= 1'b1;
            end
         end
      end
   end

   assign addr_value = addr_value_r;
   assign addr_valid = addr_valid_r;
endmodule

// File: rtl/saturn_bus_prog_reader.sv
// Drains the control unit's bus program onto the Saturn bus, one entry per
// phase-0 tick. Protocol error flag built only with SATURN_BUSPROG_CHECK_EN.
module saturn_bus_prog_reader
   import saturn_bus_prog_reader_pkg::*;
#(
   parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES,
   parameter int PROG_AW      = DEF_PROG_AW
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clk_en,
   input  logic [3:0] i_phases,
   saturn_bus_prog_reader_if.slave bus
);
   localparam int ADDR_W = 4 * ADDR_NIBBLES;

   logic [PROG_AW-1:0] rd_ptr_r;
   logic               fetch_s;
   logic               entry_is_cmd_s;
   logic [3:0]         entry_code_s;
   logic               phases_unused_s;
   bus_state_t         state_r;
   bus_state_t         state_nxt_s;
   logic               start_s;
   logic               abandon_s;
   logic               nibble_we_s;
   logic               last_nibble_s;
   logic               strobe_r;
   logic               bus_cmd_r;
   logic [3:0]         bus_nibble_r;
   logic [3:0]         last_cmd_r;
   logic [ADDR_W-1:0]  addr_value_s;
   logic               addr_valid_s;

   assign phases_unused_s = ^i_phases[3:1];
   assign entry_is_cmd_s  = bus.program_data[ENTRY_CMD_BIT];
   assign entry_code_s    = bus.program_data[3:0];
   assign fetch_s         = i_clk_en && i_phases[0] && (rd_ptr_r != bus.wr_address);

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= BUS_ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and assembler controls for the entry being fetched.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      abandon_s   = 1'b0;
      nibble_we_s = 1'b0;
      if (fetch_s && entry_is_cmd_s) begin
         // A command mid-address drops the partial value, then acts as in IDLE.
         abandon_s = (state_r == BUS_ST_ADDR);
         if (buscmd_is_addr_load(entry_code_s)) begin
            start_s     = 1'b1;
            state_nxt_s = BUS_ST_ADDR;
         end else begin
            state_nxt_s = BUS_ST_IDLE;
         end
      end else if (fetch_s) begin
         case (state_r)
            BUS_ST_ADDR: begin
               nibble_we_s = 1'b1;
               if (last_nibble_s) begin
                  state_nxt_s = BUS_ST_IDLE;
               end else begin
                  state_nxt_s = BUS_ST_ADDR;
               end
            end
            BUS_ST_IDLE: state_nxt_s = BUS_ST_IDLE;
            default:     state_nxt_s = BUS_ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Read pointer and bus replay registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rd_ptr_r     <= '0;
         strobe_r     <= 1'b0;
         bus_cmd_r    <= 1'b0;
         bus_nibble_r <= 4'h0;
         last_cmd_r   <= 4'h0;
      end else begin
         strobe_r <= fetch_s;
         if (fetch_s) begin
            rd_ptr_r     <= rd_ptr_r + PROG_AW'(1);
            bus_cmd_r    <= entry_is_cmd_s;
            bus_nibble_r <= entry_code_s;
            if (entry_is_cmd_s) begin
               last_cmd_r <= entry_code_s;
            end
         end
      end
   end

   saturn_bus_addr_assembler #(.ADDR_NIBBLES(ADDR_NIBBLES)) u_addr_asm (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .start       (start_s),
      .abandon     (abandon_s),
      .nibble_we   (nibble_we_s),
      .nibble      (entry_code_s),
      .last_nibble (last_nibble_s),
      .addr_value  (addr_value_s),
      .addr_valid  (addr_valid_s)
   );

`ifdef SATURN_BUSPROG_CHECK_EN
   logic proto_err_s;
   logic error_r;

   assign proto_err_s = fetch_s && entry_is_cmd_s &&
                        ((state_r == BUS_ST_ADDR) || !buscmd_defined(entry_code_s));

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         error_r <= 1'b0;
      end else if (proto_err_s) begin
         error_r <= 1'b1;
      end
   end

   assign bus.error = error_r;
`else
   assign bus.error = 1'b0;
`endif

   assign bus.rd_address = rd_ptr_r;
   assign bus.bus_strobe = strobe_r;
   assign bus.bus_cmd    = bus_cmd_r;
   assign bus.bus_nibble = bus_nibble_r;
   assign bus.bus_busy   = (rd_ptr_r != bus.wr_address) || (state_r == BUS_ST_ADDR);
   assign bus.last_cmd   = last_cmd_r;
   assign bus.addr_value = addr_value_s;
   assign bus.addr_valid = addr_valid_s;
endmodule

// File: doc/saturn_bus_prog_reader.md
Name: saturn_bus_prog_reader

Overview:
Consumer end of the 32-entry, 5-bit bus program that the control unit fills. Each entry is either a command ({1,cmd}) or a data nibble ({0,nibble}). The block walks its own read pointer toward the control unit's write pointer and replays one entry per bus cycle onto the Saturn bus outputs. It reassembles 5-nibble address sequences and reports bus-busy back to the control unit.

Parameters:
ADDR_NIBBLES, 5, number of data nibbles that follow an address-load command (LOAD_PC, LOAD_DP)
PROG_AW, 5, bus-program pointer width; depth is 2**PROG_AW

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_clk_en  in  1  global clock enable
i_phases  in  4  one-hot bus phase; entries are consumed on i_phases[0]
i_program_address  in  PROG_AW  control unit's write pointer (next free slot)
o_program_address  out  PROG_AW  read pointer; indexes the control unit's program array
i_program_data  in  5  entry at o_program_address, combinational from the control unit
o_bus_strobe  out  1  one i_clk pulse per emitted entry
o_bus_cmd  out  1  1 = command cycle, 0 = data nibble
o_bus_nibble  out  4  command code or data nibble
o_bus_busy  out  1  program not drained or address sequence incomplete
o_last_cmd  out  4  most recent command code emitted
o_addr_value  out  20  last fully assembled address
o_addr_valid  out  1  one-cycle pulse when o_addr_value completes
o_error  out  1  sticky protocol error

Behaviour:
- Reset: i_reset wins over all other events in the same cycle. All outputs and the read pointer go to 0; state IDLE; addr_cnt=0.
- A fetch occurs when i_clk_en && i_phases[0] && (rd_ptr != i_program_address).
  - The entry is registered and driven on o_bus_* in the next i_clk cycle, with o_bus_strobe high for exactly 1 cycle.
  - rd_ptr increments and wraps 31->0 naturally.
  - Throughput: at most one entry per 4-phase bus cycle.
- Empty condition (rd_ptr == i_program_address): no strobe. o_bus_cmd and o_bus_nibble hold their last values.
- The writer must keep fewer than 32 outstanding entries. A full lap reads as empty and is undetectable.
- o_bus_busy = (rd_ptr != i_program_address) || (state == ADDR). Combinational from registered state.
- FSM:
  - IDLE:
    - Command entry: o_last_cmd <= cmd.
    - If cmd is BUSCMD_LOAD_PC or BUSCMD_LOAD_DP: addr_cnt <= ADDR_NIBBLES and go to ADDR.
    - Any other command (RESET, PC_READ, ...): emitted only; stay in IDLE.
    - Data entry in IDLE: emitted as plain data; no address effect.
  - ADDR:
    - Each data entry writes addr_shadow[(ADDR_NIBBLES-addr_cnt)*4 +: 4], LSB nibble first, then decrements addr_cnt.
    - When addr_cnt reaches 0: o_addr_value <= completed shadow, o_addr_valid pulses in the same cycle as that nibble's strobe, return to IDLE.
    - Command entry in ADDR: flag error; abandon the partial address (o_addr_value unchanged); process the command as if in IDLE.
- i_clk_en low freezes everything except reset. Any pending strobe was already a 1-cycle pulse and is not stretched.
- A write-pointer advance in the same cycle as a fetch does not affect that fetch. The new entry is seen at the next phase-0 tick.

Optional Feature:
SATURN_BUSPROG_CHECK_EN
- Defined: o_error sets on a command received while in ADDR, and on an undefined command code. It clears only on i_reset.
- Undefined: o_error is tied 0 and the ADDR abandon rule still applies silently.

Decomposition:
- BUSCMD_* codes come from the shared buscmd definitions; no local copies.
- Add ENTRY_CMD_BIT=4 and the FSM state encodings (IDLE, ADDR) to the shared bus definitions.
- One natural sub-module: saturn_bus_addr_assembler, holding addr_cnt, the shadow register and the valid pulse.

Test Plan:
- Reset drain: after reset, write {1,LOAD_PC},{0,5},{0,4},{0,3},{0,2},{0,1}. Expect 6 strobes, one per phase-0 tick. o_addr_value=20'h12345 with o_addr_valid pulse on the 6th strobe. o_bus_busy falls after it.
- Empty hold: i_program_address == o_program_address for 8 bus cycles. Expect no strobe, o_bus_busy=0, outputs stable.
- Wrap: preset both pointers to 30, write 4 entries. Expect reads at 30, 31, 0, 1, and final o_program_address=2.
- Interrupted address: LOAD_PC, then 2 nibbles, then {1,PC_READ}. With SATURN_BUSPROG_CHECK_EN, o_error=1. o_last_cmd=PC_READ, o_addr_value unchanged, state IDLE.
- Clock enable stall: drop i_clk_en for 3 bus cycles mid-sequence. Expect no pointer motion and the sequence to resume with identical output order.
- Mid-sequence reset: assert i_reset after the 3rd address nibble. Expect all outputs 0, o_program_address=0, no o_addr_valid.
